// File: rtl/qbus_master.sv
// QBUS single-transfer bus master: DATI, DATO and DATOB cycles with address setup,
// a two-flop reply synchronizer and a reply timeout that ends the cycle with err.
module qbus_master #(
    parameter int ASETUP = 2,
    parameter int TMO    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic        byte_wr,
    input  logic [15:0] addr,
    input  logic [15:0] wdat,
    output logic [15:0] rdat,
    output logic        ack,
    output logic        err,
    output logic        busy,
    output logic [15:0] ad_out,
    output logic        ad_oe,
    input  logic [15:0] ad_in_n,
    output logic        sync_n,
    output logic        din_n,
    output logic        dout_n,
    output logic        wtbt_n,
    output logic        bs_n,
    input  logic        rply_n
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADR  = 3'd1;
    localparam logic [2:0] S_SYN  = 3'd2;
    localparam logic [2:0] S_DAT  = 3'd3;
    localparam logic [2:0] S_WRPY = 3'd4;
    localparam logic [2:0] S_WNEG = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam logic [7:0] ADR_LAST = 8'(ASETUP - 1);
    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    logic [2:0]  state_r;
    logic [7:0]  cnt_r;
    logic        wr_r;
    logic        byte_r;
    logic        addr0_r;
    logic [15:0] wdat_r;
    logic        rply_meta_r;
    logic        rply_sync_r;
    logic        rply_s;
    logic [15:0] lane_s;

    logic [15:0] rdat_r;
    logic        ack_r;
    logic        err_r;
    logic        busy_r;
    logic [15:0] ad_out_r;
    logic        ad_oe_r;
    logic        sync_n_r;
    logic        din_n_r;
    logic        dout_n_r;
    logic        wtbt_n_r;
    logic        bs_n_r;

    // Bring the asynchronous reply into the clock domain, active high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rply_meta_r <= 1'b0;
            rply_sync_r <= 1'b0;
        end else begin
            rply_meta_r <= ~rply_n;
            rply_sync_r <= rply_meta_r;
        end
    end

    assign rply_s = rply_sync_r;

    // Write data placement: a byte goes on the lane selected by the low address bit.
    always_comb begin
        if (!byte_r) begin
            lane_s = wdat_r;
        end else if (addr0_r) begin
            lane_s = {wdat_r[7:0], 8'h00};
        end else begin
            lane_s = {8'h00, wdat_r[7:0]};
        end
    end

    // Cycle sequencer; every bus strobe is a register updated on state transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_IDLE;
            cnt_r    <= 8'd0;
            wr_r     <= 1'b0;
            byte_r   <= 1'b0;
            addr0_r  <= 1'b0;
            wdat_r   <= 16'h0000;
            rdat_r   <= 16'h0000;
            ack_r    <= 1'b0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
            ad_out_r <= 16'h0000;
            ad_oe_r  <= 1'b0;
            sync_n_r <= 1'b1;
            din_n_r  <= 1'b1;
            dout_n_r <= 1'b1;
            wtbt_n_r <= 1'b1;
            bs_n_r   <= 1'b1;
        end else begin
            ack_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (req) begin
                        wr_r     <= wr;
                        byte_r   <= byte_wr;
                        addr0_r  <= addr[0];
                        wdat_r   <= wdat;
                        busy_r   <= 1'b1;
                        err_r    <= 1'b0;
                        ad_out_r <= addr;
                        ad_oe_r  <= 1'b1;
                        wtbt_n_r <= ~wr;
                        bs_n_r   <= ~(addr[15:13] == 3'b111);
                        cnt_r    <= 8'd0;
                        state_r  <= S_ADR;
                    end else begin
                        state_r  <= S_IDLE;
                    end
                end
                S_ADR: begin
                    if (cnt_r >= ADR_LAST) begin
                        sync_n_r <= 1'b0;
                        state_r  <= S_SYN;
                    end else begin
                        cnt_r    <= cnt_r + 8'd1;
                    end
                end
                S_SYN: begin
                    cnt_r   <= 8'd0;
                    state_r <= S_DAT;
                    if (wr_r) begin
                        ad_out_r <= lane_s;
                        wtbt_n_r <= ~byte_r;
                    end else begin
                        ad_oe_r  <= 1'b0;
                        din_n_r  <= 1'b0;
                    end
                end
                S_DAT: begin
                    state_r <= S_WRPY;
                    // The timeout window starts when the data strobe itself asserts.
                    if (wr_r) begin
                        dout_n_r <= 1'b0;
                        cnt_r    <= 8'd0;
                    end else begin
                        cnt_r    <= cnt_r + 8'd1;
                    end
                end
                S_WRPY: begin
                    if (rply_s) begin
                        if (!wr_r) begin
                            rdat_r <= ~ad_in_n;
                        end else begin
                            rdat_r <= rdat_r;
                        end
                        din_n_r  <= 1'b1;
                        dout_n_r <= 1'b1;
                        state_r  <= S_WNEG;
                    end else if (cnt_r >= TMO_LAST) begin
                        din_n_r  <= 1'b1;
                        dout_n_r <= 1'b1;
                        err_r    <= 1'b1;
                        ack_r    <= 1'b1;
                        busy_r   <= 1'b0;
                        state_r  <= S_DONE;
                    end else begin
                        cnt_r    <= cnt_r + 8'd1;
                    end
                end
                S_WNEG: begin
                    if (!rply_s) begin
                        sync_n_r <= 1'b1;
                        ad_oe_r  <= 1'b0;
                        wtbt_n_r <= 1'b1;
                        bs_n_r   <= 1'b1;
                        ack_r    <= 1'b1;
                        busy_r   <= 1'b0;
                        state_r  <= S_DONE;
                    end else begin
                        state_r  <= S_WNEG;
                    end
                end
                S_DONE: begin
                    // A timed-out cycle still holds SYNC and the bus here; release everything.
                    sync_n_r <= 1'b1;
                    din_n_r  <= 1'b1;
                    dout_n_r <= 1'b1;
                    ad_oe_r  <= 1'b0;
                    wtbt_n_r <= 1'b1;
                    bs_n_r   <= 1'b1;
                    state_r  <= S_IDLE;
                end
                default: begin
                    sync_n_r <= 1'b1;
                    din_n_r  <= 1'b1;
                    dout_n_r <= 1'b1;
                    ad_oe_r  <= 1'b0;
                    wtbt_n_r <= 1'b1;
                    bs_n_r   <= 1'b1;
                    busy_r   <= 1'b0;
                    state_r  <= S_IDLE;
                end
            endcase
        end
    end

    assign rdat   = rdat_r;
    assign ack    = ack_r;
    assign err    = err_r;
    assign busy   = busy_r;
    assign ad_out = ad_out_r;
    assign ad_oe  = ad_oe_r;
    assign sync_n = sync_n_r;
    assign din_n  = din_n_r;
    assign dout_n = dout_n_r;
    assign wtbt_n = wtbt_n_r;
    assign bs_n   = bs_n_r;

endmodule

// File: tb/tb_qbus_master.sv
// Directed bench for qbus_master: a QBUS slave model answers cycles, a scoreboard
// checks every ack, and a protocol monitor checks strobe ordering each clock.
module tb_qbus_master;

    localparam int ASETUP = 2;
    localparam int TMO    = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        wr;
    logic        byte_wr;
    logic [15:0] addr;
    logic [15:0] wdat;
    logic [15:0] rdat;
    logic        ack;
    logic        err;
    logic        busy;
    logic [15:0] ad_out;
    logic        ad_oe;
    logic [15:0] ad_in_n = 16'hFFFF;
    logic        sync_n;
    logic        din_n;
    logic        dout_n;
    logic        wtbt_n;
    logic        bs_n;
    logic        rply_n = 1'b1;

    always #5 clk = ~clk;

    qbus_master #(.ASETUP(ASETUP), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .byte_wr(byte_wr),
        .addr(addr), .wdat(wdat), .rdat(rdat), .ack(ack), .err(err), .busy(busy),
        .ad_out(ad_out), .ad_oe(ad_oe), .ad_in_n(ad_in_n),
        .sync_n(sync_n), .din_n(din_n), .dout_n(dout_n), .wtbt_n(wtbt_n), .bs_n(bs_n),
        .rply_n(rply_n)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        chk_rd;
        logic [15:0] rd;
        logic        er;
    } exp_t;

    exp_t sb_q[$];

    // Slave model controls, written only by the stimulus process.
    logic resp_en    = 1'b1;
    int   resp_delay = 3;
    int   rply_hold  = 0;

    // Slave model: latches the address at SYNC, replies resp_delay clocks into DIN/DOUT.
    logic [15:0] mem [0:255];
    logic        preloaded = 1'b0;
    logic        r_sync_prev = 1'b1;
    logic [15:0] r_addr = 16'h0000;
    int          r_st = 0;
    int          r_cnt = 0;
    int          h_cnt = 0;

    always @(negedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
            mem[8'h00] = 16'o123456;
            mem[8'h40] = 16'hBEEF;
            preloaded = 1'b1;
        end
        if (!sync_n && r_sync_prev) r_addr = ad_out;
        r_sync_prev = sync_n;
        if (r_st == 0) begin
            if (resp_en && (!din_n || !dout_n)) begin
                r_cnt++;
                if (r_cnt == resp_delay) begin
                    if (!dout_n) begin
                        if (!wtbt_n) begin
                            if (r_addr[0]) mem[r_addr[8:1]][15:8] = ad_out[15:8];
                            else           mem[r_addr[8:1]][7:0]  = ad_out[7:0];
                        end else begin
                            mem[r_addr[8:1]] = ad_out;
                        end
                    end else begin
                        ad_in_n = ~mem[r_addr[8:1]];
                    end
                    rply_n = 1'b0;
                    r_st   = 1;
                end
            end else begin
                r_cnt = 0;
            end
        end else if (din_n && dout_n) begin
            if (h_cnt >= rply_hold) begin
                rply_n  = 1'b1;
                ad_in_n = 16'hFFFF;
                r_st    = 0;
                r_cnt   = 0;
                h_cnt   = 0;
            end else begin
                h_cnt++;
            end
        end
    end

    // Scoreboard and protocol monitor.
    int          ack_cnt = 0;
    int          bs_low_cnt = 0;
    int          setup_cnt = 0;
    int          din_run = 0;
    int          din_last = 0;
    logic        ack_prev = 1'b0;
    logic        sync_prev = 1'b1;
    logic        dout_prev = 1'b1;
    logic        din_prev = 1'b1;
    logic [9:0]  cap = 10'h3FF;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (ack) begin
            ack_cnt++;
            check("busy_low_at_ack", {31'd0, busy}, 32'd0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack=1 expected no ack at %0t", $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("ack_err", {31'd0, err}, {31'd0, mon_e.er});
                if (mon_e.chk_rd) check("ack_rdat", {16'd0, rdat}, {16'd0, mon_e.rd});
            end
        end
        if (ack_prev) check("idle_after_ack", {28'd0, sync_n, din_n, dout_n, ad_oe}, 32'hE);
        ack_prev = ack;
        if (!sync_n || !din_n || !dout_n)
            check("strobe_order", {30'd0, (!din_n && !dout_n), ((!din_n || !dout_n) && sync_n)}, 32'd0);
        if (!sync_n && sync_prev) check("addr_setup", {31'd0, (setup_cnt >= ASETUP)}, 32'd1);
        if (sync_n && !sync_prev) check("sync_release", {29'd0, din_n, dout_n, rply_n}, 32'h7);
        if (!ad_oe) setup_cnt = 0;
        else if (sync_n) setup_cnt++;
        if (!dout_n && dout_prev) cap = {bs_n, wtbt_n, ad_out[15:8]};
        if (!din_n) din_run++;
        else if (!din_prev) begin
            din_last = din_run;
            din_run  = 0;
        end
        if (!bs_n) bs_low_cnt++;
        sync_prev = sync_n;
        dout_prev = dout_n;
        din_prev  = din_n;
    end

    // One bus cycle; returns on the clock that shows ack so the next can follow back to back.
    task automatic run_cycle(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d,
                             input logic extra_req, input logic chk_rd, input logic [15:0] rd_exp,
                             input logic er_exp);
        int n;
        sb_q.push_back('{chk_rd: chk_rd, rd: rd_exp, er: er_exp});
        @(negedge clk);
        req = 1'b1; wr = w; byte_wr = b; addr = a; wdat = d;
        @(negedge clk);
        req = 1'b0;
        check("err_clear_on_accept", {30'd0, err, busy}, 32'd1);
        n = 0;
        while (!ack && n < 300) begin
            @(negedge clk);
            req = (extra_req && n >= 2 && n < 8) ? 1'b1 : 1'b0;
            n++;
        end
        req = 1'b0;
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack after %0d clocks expected ack", n);
        end
    endtask

    int a0;
    int b0;
    int n6;

    initial begin
        rst = 1'b1; req = 1'b0; wr = 1'b0; byte_wr = 1'b0; addr = 16'h0000; wdat = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset_strobes", {23'd0, sync_n, din_n, dout_n, wtbt_n, bs_n, ad_oe, ack, err, busy}, 32'h1F0);
        check("reset_rdat", {16'd0, rdat}, 32'd0);
        check("reset_ad_out", {16'd0, ad_out}, 32'd0);
        rst = 1'b0;

        // Plain word read, reply three clocks into DIN.
        a0 = ack_cnt; b0 = bs_low_cnt;
        run_cycle(1'b0, 1'b0, 16'o001000, 16'h0000, 1'b0, 1'b1, 16'o123456, 1'b0);
        repeat (3) @(negedge clk);
        check("read_ack_once", ack_cnt - a0, 32'd1);
        check("read_bs_high", bs_low_cnt - b0, 32'd0);

        // Odd byte write into the I/O page.
        run_cycle(1'b1, 1'b1, 16'o177567, 16'h0041, 1'b0, 1'b0, 16'h0000, 1'b0);
        repeat (2) @(negedge clk);
        check("datob_data_phase", {22'd0, cap}, {22'd0, 1'b0, 1'b0, 8'h41});
        check("datob_mem", {16'd0, mem[8'hBB]}, 32'h4100);
        check("rdat_hold_after_write", {16'd0, rdat}, {16'd0, 16'o123456});

        // No responder: DIN must drop after TMO clocks with err.
        resp_en = 1'b0;
        run_cycle(1'b0, 1'b0, 16'o003000, 16'h0000, 1'b0, 1'b1, 16'o123456, 1'b1);
        repeat (2) @(negedge clk);
        check("tmo_din_len", din_last, TMO);
        check("err_held", {31'd0, err}, 32'd1);
        resp_en = 1'b1;

        // Reply held late, with req pulses while busy.
        rply_hold = 5;
        a0 = ack_cnt;
        run_cycle(1'b0, 1'b0, 16'o000200, 16'h0000, 1'b1, 1'b1, 16'hBEEF, 1'b0);
        repeat (20) @(negedge clk);
        check("busy_req_ignored", ack_cnt - a0, 32'd1);
        check("idle_after_hold", {31'd0, busy}, 32'd0);
        rply_hold = 0;

        // Reset while a write waits for a reply.
        resp_en = 1'b0;
        a0 = ack_cnt;
        @(negedge clk);
        req = 1'b1; wr = 1'b1; byte_wr = 1'b0; addr = 16'o000100; wdat = 16'o177777;
        @(negedge clk);
        req = 1'b0;
        n6 = 0;
        while (dout_n && n6 < 50) begin
            @(negedge clk);
            n6++;
        end
        check("wr_reached_wrpy", {31'd0, dout_n}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_abandon", {25'd0, sync_n, din_n, dout_n, wtbt_n, bs_n, ad_oe, busy}, 32'h7C);
        repeat (5) @(negedge clk);
        check("rst_no_ack", ack_cnt - a0, 32'd0);
        resp_en = 1'b1;

        // Back-to-back word write and read of the same location.
        run_cycle(1'b1, 1'b0, 16'o000100, 16'o052525, 1'b0, 1'b0, 16'h0000, 1'b0);
        run_cycle(1'b0, 1'b0, 16'o000100, 16'h0000, 1'b0, 1'b1, 16'o052525, 1'b0);
        repeat (4) @(negedge clk);
        check("mem_word_written", {16'd0, mem[8'h20]}, {16'd0, 16'o052525});
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
